// File: rtl/bp_fe_pkg.sv
// Shared fetch-engine definitions.
//   rv64_eaddr_width_gp : effective address width
//   btb_offset_width_gp : low address bits below the BTB index; the BTB and its
//                         update queue both use this so they agree on the index split
//   bp_fe_btb_update_s  : one pending BTB write (branch site + target)
package bp_fe_pkg;

    localparam int unsigned rv64_eaddr_width_gp = 64;
    localparam int unsigned btb_offset_width_gp = 2;

    typedef struct packed {
        logic [rv64_eaddr_width_gp-1:0] br_addr;
        logic [rv64_eaddr_width_gp-1:0] tgt;
    } bp_fe_btb_update_s;

endpackage

// File: rtl/bp_fe_btb_update_match.sv
// Index comparator for the BTB update queue.
//   entry_idx_i : BTB index held by each queue entry
//   valid_i     : entries taking part in the comparison
//   idx_i       : index of the incoming update
//   match_oh_o  : one-hot match vector (at most one entry per index is held)
//   hit_o       : some entry matched
module bp_fe_btb_update_match
    import bp_fe_pkg::*;
#(
    parameter int unsigned queue_els_p     = 4,
    parameter int unsigned btb_idx_width_p = 6
) (
    input  logic [queue_els_p-1:0][btb_idx_width_p-1:0] entry_idx_i,
    input  logic [queue_els_p-1:0]                      valid_i,
    input  logic [btb_idx_width_p-1:0]                  idx_i,
    output logic [queue_els_p-1:0]                      match_oh_o,
    output logic                                        hit_o
);

    always_comb begin
        match_oh_o = '0;
        for (int i = 0; i < queue_els_p; i++) begin
            match_oh_o[i] = valid_i[i] & (entry_idx_i[i] == idx_i);
        end
    end

    assign hit_o = |match_oh_o;

endmodule

// File: rtl/bp_fe_btb_update_queue.sv
// Coalescing queue between backend branch resolution and the BTB write port.
// Taken updates are buffered (one entry per BTB index) and drained when fetch
// is not reading the BTB, when the queue is full, or when the head has been
// held off for stall_max_p cycles.
//   clk_i, reset_n_i             : clock, asynchronous active-low reset
//   upd_v_i / upd_ready_o        : update handshake from the backend
//   upd_br_addr_i, upd_tgt_i     : branch site and resolved target
//   upd_taken_i                  : not-taken updates are accepted and dropped
//   fe_r_v_i                     : fetch is reading the BTB this cycle
//   w_v_o, w_addr_o, br_tgt_o    : BTB write port (always accepted)
//   empty_o                      : queue holds no entries
module bp_fe_btb_update_queue
    import bp_fe_pkg::*;
#(
    parameter int unsigned btb_idx_width_p = 6,
    parameter int unsigned queue_els_p     = 4,
    parameter int unsigned stall_max_p     = 8,
    localparam int unsigned eaddr_width_lp      = rv64_eaddr_width_gp,
    localparam int unsigned btb_offset_width_lp = btb_offset_width_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      upd_v_i,
    output logic                      upd_ready_o,
    input  logic [eaddr_width_lp-1:0] upd_br_addr_i,
    input  logic [eaddr_width_lp-1:0] upd_tgt_i,
    input  logic                      upd_taken_i,
    input  logic                      fe_r_v_i,
    output logic                      w_v_o,
    output logic [eaddr_width_lp-1:0] w_addr_o,
    output logic [eaddr_width_lp-1:0] br_tgt_o,
    output logic                      empty_o
);

    localparam int unsigned ptr_w_lp = $clog2(queue_els_p);
    localparam int unsigned cnt_w_lp = $clog2(stall_max_p + 1);
    localparam logic [cnt_w_lp-1:0] stall_max_lp = cnt_w_lp'(stall_max_p);

    bp_fe_btb_update_s mem_q [queue_els_p];
    logic [queue_els_p-1:0] valid_q, valid_d;
    // Pointers carry an extra wrap bit to tell full from empty.
    logic [ptr_w_lp:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] starve_q, starve_d;
    logic ready_q;

    logic [ptr_w_lp-1:0] rd_idx, wr_idx;
    logic full, empty, deq, enq_fire, alloc, hit;
    logic [btb_idx_width_p-1:0] upd_idx;
    logic [queue_els_p-1:0][btb_idx_width_p-1:0] entry_idx;
    logic [queue_els_p-1:0] deq_oh, tail_oh, match_oh, match_valid, wen;

    assign rd_idx = rptr_q[ptr_w_lp-1:0];
    assign wr_idx = wptr_q[ptr_w_lp-1:0];
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp]) &&
                    (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);

    // ready_q holds ready low through reset and the first edge after release.
    assign upd_ready_o = ready_q & ~full;
    assign empty_o     = empty;
    assign w_v_o       = ~empty & (~fe_r_v_i | full | (starve_q == stall_max_lp));
    assign w_addr_o    = mem_q[rd_idx].br_addr;
    assign br_tgt_o    = mem_q[rd_idx].tgt;

    assign deq      = w_v_o;
    assign enq_fire = upd_v_i & upd_ready_o & upd_taken_i;
    assign upd_idx  = upd_br_addr_i[btb_offset_width_lp +: btb_idx_width_p];
    assign deq_oh   = deq ? (queue_els_p'(1) << rd_idx) : '0;
    assign tail_oh  = queue_els_p'(1) << wr_idx;

    always_comb begin
        entry_idx = '0;
        for (int i = 0; i < queue_els_p; i++) begin
            entry_idx[i] = mem_q[i].br_addr[btb_offset_width_lp +: btb_idx_width_p];
        end
    end

    // A departing head must not absorb a new update, or that update would be lost.
    assign match_valid = valid_q & ~deq_oh;

    bp_fe_btb_update_match #(
        .queue_els_p     (queue_els_p),
        .btb_idx_width_p (btb_idx_width_p)
    ) u_match (
        .entry_idx_i (entry_idx),
        .valid_i     (match_valid),
        .idx_i       (upd_idx),
        .match_oh_o  (match_oh),
        .hit_o       (hit)
    );

    assign alloc = enq_fire & ~hit;
    assign wen   = (alloc ? tail_oh : '0) | ({queue_els_p{enq_fire}} & match_oh);

    always_comb begin
        valid_d = (valid_q & ~deq_oh) | (alloc ? tail_oh : '0);
        wptr_d  = alloc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = deq ? rptr_q + 1'b1 : rptr_q;
        if (deq || empty) begin
            starve_d = '0;
        end else if (starve_q != stall_max_lp) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            starve_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            starve_q <= starve_d;
            ready_q  <= 1'b1;
        end
    end

    // Payload storage needs no reset; valids qualify it.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < queue_els_p; i++) begin
            if (wen[i]) begin
                mem_q[i] <= '{br_addr: upd_br_addr_i, tgt: upd_tgt_i};
            end
        end
    end

endmodule
